// File: rtl/mips8_loader_pkg.sv
// Shared definitions for the MIPS8 program loader: register word offsets,
// CTRL/STATUS bit positions and the byte-serializer state encoding.
package mips8_loader_pkg;

    // Register word index, taken from wbs_adr_i[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bits
    localparam int CTRL_HOLD      = 0;
    localparam int CTRL_CLR_CSUM  = 1;
    localparam int CTRL_CLR_FLAGS = 2;

    // STATUS bits
    localparam int STAT_BUSY    = 0;
    localparam int STAT_OVF     = 1;
    localparam int STAT_WR_RUN  = 2;
    localparam int STAT_CSUM_LO = 8;

    typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} ser_state_t;

    // Byte lane (LSB first) presented while in a given serializer state
    function automatic logic [1:0] lane_of(input ser_state_t s);
        case (s)
            B1:      return 2'd1;
            B2:      return 2'd2;
            B3:      return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mips8_byte_serializer.sv
// Splits a 32-bit word into four byte slots (LSB first), strobing only the
// selected lanes, and owns the byte-address counter that follows each emit.
module mips8_byte_serializer
    import mips8_loader_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    output logic          ready,
    input  logic [31:0]   word,
    input  logic [3:0]    sel,
    input  logic          addr_load,
    input  logic [AW-1:0] addr_wdata,
    output logic [AW-1:0] addr,
    output logic          byte_we,
    output logic [7:0]    byte_data,
    output logic          wrap,
    output logic          done,
    output logic          busy
);

    ser_state_t  state;
    ser_state_t  state_next;
    logic [31:0] word_q;
    logic [3:0]  sel_q;
    logic [1:0]  lane;
    logic        active;

    // State register
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Word/select capture, address counter and end-of-load pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            sel_q  <= '0;
            addr   <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == B3);
            if (valid && ready) begin
                word_q <= word;
                sel_q  <= sel;
            end
            // The top never loads the address while busy, so load and
            // increment cannot collide in practice.
            if (addr_load)    addr <= addr_wdata;
            else if (byte_we) addr <= addr + 1'b1;
        end
    end

    // Next-state: one slot per byte lane, then back to IDLE
    always_comb begin
        // NOTE: assigning a default before the case keeps this block purely
        // combinational; a missed branch would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = B0;
            B0:      state_next = B1;
            B1:      state_next = B2;
            B2:      state_next = B3;
            B3:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: byte strobe only for selected lanes, data zero when idle
    always_comb begin
        lane      = lane_of(state);
        active    = (state != IDLE);
        byte_we   = active && sel_q[lane];
        byte_data = active ? word_q[{lane, 3'b000} +: 8] : 8'h00;
    end

    assign wrap  = byte_we && (addr == '1);
    assign ready = (state == IDLE);
    assign busy  = ~ready;

endmodule

// File: rtl/mips8_wb_loader.sv
// Wishbone slave that loads program bytes into the MIPS8 core's instruction
// memory while holding the core in reset. Optional running byte checksum is
// built when MIPS8_LOADER_CSUM_EN is defined.
module mips8_wb_loader
    import mips8_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          AW        = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [31:0]   wbs_adr_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    output logic          core_rst_o,
    output logic          load_irq_o
);

    logic          hit;
    logic [1:0]    reg_idx;
    logic          req;
    logic          stall;
    logic          accept;
    logic          ctrl_wr;
    logic          addr_wr;
    logic          data_wr;
    logic          rd_en;
    logic          load_valid;
    logic          wr_run_set;
    logic          clr_flags;
    logic          clr_csum;
    logic          hold;
    logic          ovf;
    logic          wr_run;
    logic          busy;
    logic          ready;
    logic          wrap;
    logic [AW-1:0] addr;
    logic [7:0]    csum;
    logic [31:0]   rdata;

    // Bus decode: 16-byte window, ADDR/DATA writes stall while a load runs
    assign hit        = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_idx    = wbs_adr_i[3:2];
    assign req        = wbs_cyc_i && wbs_stb_i && hit && !wbs_ack_o;
    assign stall      = busy && wbs_we_i && (reg_idx == REG_DATA || reg_idx == REG_ADDR);
    assign accept     = req && !stall;
    assign rd_en      = accept && !wbs_we_i;
    assign ctrl_wr    = accept && wbs_we_i && (reg_idx == REG_CTRL);
    assign addr_wr    = accept && wbs_we_i && (reg_idx == REG_ADDR);
    assign data_wr    = accept && wbs_we_i && (reg_idx == REG_DATA);
    assign load_valid = data_wr && hold;
    assign wr_run_set = data_wr && !hold;
    assign clr_flags  = ctrl_wr && wbs_dat_i[CTRL_CLR_FLAGS];
    assign clr_csum   = ctrl_wr && wbs_dat_i[CTRL_CLR_CSUM];

    mips8_byte_serializer #(.AW(AW)) u_serializer (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .valid      (load_valid),
        .ready      (ready),
        .word       (wbs_dat_i),
        .sel        (wbs_sel_i),
        .addr_load  (addr_wr),
        .addr_wdata (wbs_dat_i[AW-1:0]),
        .addr       (addr),
        .byte_we    (mem_we_o),
        .byte_data  (mem_wdata_o),
        .wrap       (wrap),
        .done       (load_irq_o),
        .busy       (busy)
    );

    // Ack, read data, CTRL.hold and sticky flags (a same-cycle set beats clear)
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            hold      <= 1'b1;
            ovf       <= 1'b0;
            wr_run    <= 1'b0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= rd_en ? rdata : '0;
            if (ctrl_wr) hold <= wbs_dat_i[CTRL_HOLD];
            ovf    <= wrap       || (ovf    && !clr_flags);
            wr_run <= wr_run_set || (wr_run && !clr_flags);
        end
    end

`ifdef MIPS8_LOADER_CSUM_EN
    // Running 8-bit checksum of emitted bytes; a clear keeps a same-cycle byte
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)      csum <= 8'h00;
        else if (clr_csum) csum <= mem_we_o ? mem_wdata_o : 8'h00;
        else if (mem_we_o) csum <= csum + mem_wdata_o;
    end
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_adr_i[1:0]};
`else
    assign csum = 8'h00;
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_adr_i[1:0], clr_csum};
`endif

    // Register read mux
    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:   rdata[CTRL_HOLD] = hold;
            REG_ADDR:   rdata[AW-1:0]    = addr;
            REG_STATUS: begin
                rdata[STAT_BUSY]                 = busy;
                rdata[STAT_OVF]                  = ovf;
                rdata[STAT_WR_RUN]               = wr_run;
                rdata[STAT_CSUM_LO +: 8]         = csum;
            end
            default:    rdata = '0;
        endcase
    end

    // A pending hold release is deferred until the serializer is idle
    assign core_rst_o = hold || busy;
    assign mem_addr_o = addr;

endmodule

// File: tb/tb_mips8_wb_loader.sv
// Directed bench for mips8_wb_loader: register access, byte serialization
// timing, address wrap, stalling, hold behaviour and mid-load reset.
module tb_mips8_wb_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        core_rst_o;
    logic        load_irq_o;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic core_rst_at_ack;

    logic [7:0] log_addr[$];
    logic [7:0] log_data[$];
    int         log_cyc[$];
    int         irq_cyc[$];

    mips8_wb_loader dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .core_rst_o  (core_rst_o),
        .load_irq_o  (load_irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cycle <= cycle + 1;

    // Byte/irq monitor, sampled mid-cycle
    always @(negedge wb_clk_i) begin
        if (mem_we_o === 1'b1) begin
            log_addr.push_back(mem_addr_o);
            log_data.push_back(mem_wdata_o);
            log_cyc.push_back(cycle);
        end
        if (load_irq_o === 1'b1) irq_cyc.push_back(cycle);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        irq_cyc.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    // One Wishbone transfer; ack_cyc is the cycle in which ack was seen
    task automatic wb_xfer(input logic we, input logic [3:0] off, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int ack_cyc);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = BASE + {28'h0, off}; wbs_dat_i = d; wbs_sel_i = s;
        ack_cyc = -1;
        rd = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o === 1'b1) begin
                ack_cyc = cycle;
                rd = wbs_dat_o;
                core_rst_at_ack = core_rst_o;
                break;
            end
        end
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        check("ack_seen", (ack_cyc >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wb_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s,
                            output int ack_cyc);
        logic [31:0] rd_unused;
        wb_xfer(1'b1, off, d, s, rd_unused, ack_cyc);
    endtask

    task automatic wb_read(input logic [3:0] off, output logic [31:0] d);
        int ack_unused;
        wb_xfer(1'b0, off, 32'h0, 4'hF, d, ack_unused);
    endtask

    // Checks n logged bytes: contiguous 8-bit addresses from a0, data by lane
    task automatic check_bytes(input string tag, input int n, input logic [7:0] a0,
                               input logic [63:0] bytes);
        logic [7:0] a_exp;
        check({tag, "_count"}, log_addr.size(), n);
        a_exp = a0;
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), {24'h0, log_addr[i]}, {24'h0, a_exp});
            check($sformatf("%s_data%0d", tag, i), {24'h0, log_data[i]}, {24'h0, bytes[8*i +: 8]});
            a_exp = a_exp + 8'd1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int a1;
        int a2;
        int nack;
        logic [31:0] csum_exp;

        wb_rst_i = 1'b1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;

        // 1. Reset state
        wait_cycles(3);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("rst_core_rst", {31'h0, core_rst_o}, 32'd1);
        check("rst_ack", {31'h0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'h0);
        check("rst_mem_we", {31'h0, mem_we_o}, 32'd0);
        check("rst_mem_addr", {24'h0, mem_addr_o}, 32'h0);
        check("rst_mem_wdata", {24'h0, mem_wdata_o}, 32'h0);
        check("rst_irq", {31'h0, load_irq_o}, 32'd0);
        wb_read(4'hC, rd);
        check("rst_status", rd, 32'h0);
        wb_read(4'h0, rd);
        check("rst_ctrl", rd, 32'h1);

        // 2. Full word at 0x10
        wb_write(4'h4, 32'h10, 4'hF, a1);
        clear_log();
        wb_write(4'h8, 32'hDDCC_BBAA, 4'hF, a1);
        wait_cycles(8);
        check_bytes("t2", 4, 8'h10, 64'h0000_0000_DDCC_BBAA);
        for (int i = 0; i < 4 && i < log_cyc.size(); i++)
            check($sformatf("t2_cyc%0d", i), log_cyc[i], a1 + i);
        check("t2_irq_count", irq_cyc.size(), 1);
        if (irq_cyc.size() > 0) check("t2_irq_cyc", irq_cyc[0], a1 + 4);
        wb_read(4'h4, rd);
        check("t2_addr", rd, 32'h14);

        // 3. Sparse select 0101
        clear_log();
        wb_write(4'h8, 32'h4433_2211, 4'b0101, a1);
        wait_cycles(8);
        check_bytes("t3", 2, 8'h14, 64'h0000_0000_0000_3311);
        if (log_cyc.size() == 2) begin
            check("t3_cyc0", log_cyc[0], a1);
            check("t3_cyc1", log_cyc[1], a1 + 2);
        end
        check("t3_irq_count", irq_cyc.size(), 1);
        if (irq_cyc.size() > 0) check("t3_irq_cyc", irq_cyc[0], a1 + 4);
        wb_read(4'h4, rd);
        check("t3_addr", rd, 32'h16);

        // 4. Address wrap sets ovf; clr_flags clears it
        wb_write(4'h4, 32'hFE, 4'hF, a1);
        clear_log();
        wb_write(4'h8, 32'h0403_0201, 4'hF, a1);
        wait_cycles(8);
        check_bytes("t4", 4, 8'hFE, 64'h0000_0000_0403_0201);
        wb_read(4'hC, rd);
        check("t4_status_ovf", {29'h0, rd[2:0]}, 32'h2);
        wb_write(4'h0, 32'h5, 4'hF, a1);
        wb_read(4'hC, rd);
        check("t4_status_clr", {29'h0, rd[2:0]}, 32'h0);
        wb_read(4'h4, rd);
        check("t4_addr", rd, 32'h02);

        // 5. Back-to-back DATA writes: second ack waits for IDLE
        wb_write(4'h4, 32'h20, 4'hF, a1);
        clear_log();
        wb_write(4'h8, 32'h1312_1110, 4'hF, a1);
        wb_write(4'h8, 32'h1716_1514, 4'hF, a2);
        check("t5_ack_gap", a2 - a1, 32'd5);
        wait_cycles(8);
        check_bytes("t5", 8, 8'h20, 64'h1716_1514_1312_1110);
        check("t5_irq_count", irq_cyc.size(), 2);

        // 6. Checksum, deferred hold release, write while running
        wb_write(4'h0, 32'h3, 4'hF, a1);
        wb_write(4'h4, 32'h40, 4'hF, a1);
        clear_log();
        wb_write(4'h8, 32'h0000_9080, 4'b0011, a1);
        wb_write(4'h0, 32'h0, 4'hF, a2);
        check("t6_core_rst_busy", {31'h0, core_rst_at_ack}, 32'd1);
        wait_cycles(6);
        check("t6_core_rst_released", {31'h0, core_rst_o}, 32'd0);
        check_bytes("t6", 2, 8'h40, 64'h0000_0000_0000_9080);
`ifdef MIPS8_LOADER_CSUM_EN
        csum_exp = 32'h0000_1000;
`else
        csum_exp = 32'h0;
`endif
        wb_read(4'hC, rd);
        check("t6_status_csum", rd, csum_exp);
        clear_log();
        wb_write(4'h8, 32'hFFFF_FFFF, 4'hF, a1);
        wait_cycles(8);
        check("t6_no_bytes", log_addr.size(), 0);
        check("t6_no_irq", irq_cyc.size(), 0);
        wb_read(4'hC, rd);
        check("t6_wr_run", rd, csum_exp | 32'h4);
        wb_read(4'h4, rd);
        check("t6_addr_kept", rd, 32'h42);
        wb_write(4'h0, 32'h4, 4'hF, a1);
        wb_read(4'hC, rd);
        check("t6_wr_run_clr", rd, csum_exp);

        // 7. Address outside the window is never acked
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE + 32'h10;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o === 1'b1) nack++;
        end
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("t7_no_ack", nack, 0);

        // 8. Reset in the middle of a load drops remaining bytes
        wb_write(4'h0, 32'h1, 4'hF, a1);
        wb_write(4'h4, 32'h50, 4'hF, a1);
        clear_log();
        wb_write(4'h8, 32'hAABB_CCDD, 4'hF, a1);
        wb_rst_i = 1'b1;
        wait_cycles(2);
        wb_rst_i = 1'b0;
        wait_cycles(6);
        check_bytes("t8", 2, 8'h50, 64'h0000_0000_0000_CCDD);
        check("t8_no_irq", irq_cyc.size(), 0);
        check("t8_core_rst", {31'h0, core_rst_o}, 32'd1);
        wb_read(4'h4, rd);
        check("t8_addr", rd, 32'h0);
        wb_read(4'hC, rd);
        check("t8_status", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
